// File: rtl/meas_frame_tx.sv
// rtl/meas_frame_tx.sv - measurement frame serialiser feeding a byte-wide UART transmitter
// Optional sequence byte after HEADER enabled by defining FRAME_SEQ_EN.
module meas_frame_tx #(
  parameter int          NUM_WORDS  = 2,
  parameter int          WORD_BYTES = 4,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter logic [7:0]  TRAILER    = 8'h5A
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WORDS*WORD_BYTES*8-1:0] data_in,
  input  logic                            data_ready,
  input  logic                            uart_tx_done,
  output logic [7:0]                      uart_tx_data,
  output logic                            uart_tx_en,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            frame_drop
);

  localparam int NB = NUM_WORDS * WORD_BYTES;
`ifdef FRAME_SEQ_EN
  localparam int SEQ_BYTES = 1;
`else
  localparam int SEQ_BYTES = 0;
`endif
  localparam int PAY_START = 1 + SEQ_BYTES;
  localparam int LEN       = NB + 3 + SEQ_BYTES;

  localparam logic [5:0] LEN_L     = 6'(LEN);
  localparam logic [5:0] CSUM_IDX  = 6'(LEN - 2);
  localparam logic [5:0] PAY_END_L = 6'(PAY_START + NB);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, PULSE, GAP} state_t;

  state_t          state;
  logic            sync_q1;
  logic            sync_q2;
  logic            request;
  logic [NB*8-1:0] snap;
  logic [5:0]      idx;
  logic [7:0]      csum;
  logic [7:0]      payload_byte;
  logic [7:0]      next_byte;
  logic            next_summed;
`ifdef FRAME_SEQ_EN
  logic [7:0]      seq;
`endif

  assign request = sync_q1 & ~sync_q2;

  // Two-flop synchroniser for the asynchronous data_ready level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= data_ready;
      sync_q2 <= sync_q1;
    end
  end

  // Pick the snapshot byte for the current index: words in order, each word MSB first.
  always_comb begin
    payload_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx == 6'(PAY_START + i))
        payload_byte = snap[((i / WORD_BYTES) * WORD_BYTES + WORD_BYTES - 1 - (i % WORD_BYTES)) * 8 +: 8];
    end
  end

  // Byte to issue at the current index and whether it feeds the checksum.
  always_comb begin
    next_summed = (idx != 6'd0) && (idx < PAY_END_L);
    if (idx == 6'd0)
      next_byte = HEADER;
`ifdef FRAME_SEQ_EN
    else if (idx == 6'd1)
      next_byte = seq;
`endif
    else if (idx < PAY_END_L)
      next_byte = payload_byte;
    else if (idx == CSUM_IDX)
      next_byte = csum;
    else
      next_byte = TRAILER;
  end

  // Frame FSM: snapshot, hand bytes to the UART one at a time, running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      uart_tx_data <= 8'h00;
      uart_tx_en   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_drop   <= 1'b0;
      snap         <= '0;
      idx          <= 6'd0;
      csum         <= 8'h00;
`ifdef FRAME_SEQ_EN
      seq          <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      frame_drop <= request & busy;
      case (state)
        IDLE: begin
          if (request) begin
            snap  <= data_in;
            idx   <= 6'd0;
            csum  <= 8'h00;
            busy  <= 1'b1;
            state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (uart_tx_done) begin
            uart_tx_data <= next_byte;
            uart_tx_en   <= 1'b1;
            idx          <= idx + 6'd1;
            if (next_summed)
              csum <= csum + next_byte;
            state <= PULSE;
          end
        end
        PULSE: begin
          uart_tx_en <= 1'b0;
          state      <= GAP;
        end
        GAP: begin
          // The UART's done flag may still be stale here, so it is not looked at.
          if (idx == LEN_L) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
`ifdef FRAME_SEQ_EN
            seq        <= seq + 8'd1;
`endif
            state      <= IDLE;
          end else begin
            state <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_frame_tx.sv
// tb/tb_meas_frame_tx.sv - directed self-checking bench for meas_frame_tx
module tb_meas_frame_tx;

`ifdef FRAME_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_ready = 1'b0;
  logic        uart_tx_done = 1'b1;
  logic [63:0] data_in = 64'h02FAF080_00989680;
  logic [15:0] data_in2 = 16'hFF02;

  logic [7:0]  uart_tx_data, uart_tx_data2;
  logic        uart_tx_en, uart_tx_en2;
  logic        busy, busy2;
  logic        frame_done, frame_done2;
  logic        frame_drop, frame_drop2;

  meas_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_ready(data_ready),
    .uart_tx_done(uart_tx_done), .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en),
    .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop)
  );

  meas_frame_tx #(.NUM_WORDS(1), .WORD_BYTES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in2), .data_ready(data_ready),
    .uart_tx_done(uart_tx_done), .uart_tx_data(uart_tx_data2), .uart_tx_en(uart_tx_en2),
    .busy(busy2), .frame_done(frame_done2), .frame_drop(frame_drop2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pay1 [8] = '{8'h00, 8'h98, 8'h96, 8'h80, 8'h02, 8'hFA, 8'hF0, 8'h80};
  logic [7:0] pay2 [2] = '{8'hFF, 8'h02};

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         en_cnt = 0, done_cnt = 0, drop_cnt = 0, done2_cnt = 0;
  logic [7:0] seq1 = 8'h00, seq2 = 8'h00;

  // Record every byte handed to either UART and count the status pulses.
  always @(negedge clk) begin
    if (uart_tx_en) begin q1.push_back(uart_tx_data); en_cnt++; end
    if (uart_tx_en2) q2.push_back(uart_tx_data2);
    if (frame_done) done_cnt++;
    if (frame_done2) done2_cnt++;
    if (frame_drop) drop_cnt++;
    if (!rst_n) begin seq1 = 8'h00; seq2 = 8'h00; end
    else begin
      if (frame_done) seq1 = seq1 + 8'd1;
      if (frame_done2) seq2 = seq2 + 8'd1;
    end
  end

  task automatic check_frame(input string tag, input bit second, input int base, input logic [7:0] seq);
    logic [7:0] e[$];
    logic [7:0] sum;
    logic [31:0] got;
    int n;
    sum = 8'h00;
    e.push_back(8'hA5);
    if (SEQ_ON) begin e.push_back(seq); sum = sum + seq; end
    if (second) begin
      foreach (pay2[i]) begin e.push_back(pay2[i]); sum = sum + pay2[i]; end
    end else begin
      foreach (pay1[i]) begin e.push_back(pay1[i]); sum = sum + pay1[i]; end
    end
    e.push_back(sum);
    e.push_back(8'h5A);
    n = second ? q2.size() : q1.size();
    check({tag, " len"}, 32'(n - base), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (base + i < n) got = second ? 32'(q2[base + i]) : 32'(q1[base + i]);
      else got = 32'hFFFF_FFFF;
      check($sformatf("%s byte%0d", tag, i), got, 32'(e[i]));
    end
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin @(negedge clk); n++; end
    check({tag, " done"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n = 0;
    while (q1.size() < target && n < 2000) begin @(negedge clk); n++; end
    check({tag, " bytes"}, 32'(q1.size() >= target), 32'd1);
  endtask

  initial begin
    int base, d0, e0, e1, dr0;
    logic [7:0] s;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst en", 32'(uart_tx_en), 32'd0);
    check("rst data", 32'(uart_tx_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(frame_done), 32'd0);
    check("rst drop", 32'(frame_drop), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    base = q1.size(); s = seq1; d0 = done_cnt;
    data_ready = 1'b1;
    wait_done("t1", d0 + 1);
    repeat (5) @(negedge clk);
    check("t1 one done", 32'(done_cnt), 32'(d0 + 1));
    check("t1 busy low", 32'(busy), 32'd0);
    check("t1 data hold", 32'(uart_tx_data), 32'h5A);
    check_frame("t1", 1'b0, base, s);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);

    // UART stall after third byte
    base = q1.size(); s = seq1; d0 = done_cnt; e0 = en_cnt;
    data_ready = 1'b1;
    wait_bytes("t2", base + 3);
    uart_tx_done = 1'b0;
    e1 = en_cnt;
    repeat (100) @(negedge clk);
    check("t2 stall en", 32'(en_cnt - e0), 32'd3);
    check("t2 stall en2", 32'(en_cnt), 32'(e1));
    check("t2 stall busy", 32'(busy), 32'd1);
    uart_tx_done = 1'b1;
    wait_done("t2", d0 + 1);
    check_frame("t2", 1'b0, base, s);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Request while busy is dropped and the snapshot is kept
    base = q1.size(); s = seq1; d0 = done_cnt; dr0 = drop_cnt;
    data_ready = 1'b1;
    wait_bytes("t3", base + 2);
    data_in = 64'h11223344_55667788;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    data_ready = 1'b1;
    wait_done("t3", d0 + 1);
    check("t3 drop", 32'(drop_cnt - dr0), 32'd1);
    check_frame("t3", 1'b0, base, s);
    data_ready = 1'b0;
    data_in = 64'h02FAF080_00989680;
    repeat (4) @(negedge clk);

    // Request landing on the return-to-IDLE cycle is dropped
    base = q1.size(); s = seq1; d0 = done_cnt; dr0 = drop_cnt;
    data_ready = 1'b1;
    wait_bytes("t4", base + 2);
    data_ready = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (uart_tx_en && uart_tx_data == 8'h5A) break;
    end
    data_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("t4 drop", 32'(drop_cnt - dr0), 32'd1);
    check("t4 done", 32'(done_cnt - d0), 32'd1);
    check("t4 idle", 32'(busy), 32'd0);
    check_frame("t4", 1'b0, base, s);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-frame, then a fresh frame
    base = q1.size();
    data_ready = 1'b1;
    wait_bytes("t5", base + 5);
    rst_n = 1'b0;
    data_ready = 1'b0;
    #1;
    check("t5 rst en", 32'(uart_tx_en), 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst data", 32'(uart_tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = en_cnt; d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("t5 no residual en", 32'(en_cnt), 32'(e0));
    check("t5 no residual done", 32'(done_cnt), 32'(d0));
    base = q1.size(); s = seq1;
    data_ready = 1'b1;
    wait_done("t5", d0 + 1);
    check_frame("t5", 1'b0, base, s);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Narrow configuration: one 16-bit word
    base = q2.size(); s = seq2; d0 = done2_cnt;
    data_ready = 1'b1;
    for (int n = 0; n < 500 && done2_cnt == d0; n++) @(negedge clk);
    check("t6 done", 32'(done2_cnt - d0), 32'd1);
    check_frame("t6", 1'b1, base, s);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/meas_frame_tx.md
MEAS_FRAME_TX -- requirements
Module: meas_frame_tx

Interface
REQ-001 Parameter NUM_WORDS, default 2: number of measurement words per frame, range 1..8.
REQ-002 Parameter WORD_BYTES, default 4: bytes per word, range 1..4.
REQ-003 Parameter HEADER, default 8'hA5: frame start byte.
REQ-004 Parameter TRAILER, default 8'h5A: frame end byte.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data_in  input  NUM_WORDS*WORD_BYTES*8  measurement words; word 0 in the LSBs.
REQ-008 data_ready  input  1  level from the latch stage; its rising edge requests a frame.
REQ-009 uart_tx_done  input  1  high = UART idle and ready for a byte.
REQ-010 uart_tx_data  output  8  byte to UART.
REQ-011 uart_tx_en  output  1  one-cycle start pulse to UART.
REQ-012 busy  output  1  high from snapshot until the trailer handoff completes.
REQ-013 frame_done  output  1  one-cycle pulse after the trailer is handed off.
REQ-014 frame_drop  output  1  one-cycle pulse when a request is rejected because busy is high.

Function
REQ-015 data_ready shall pass through a two-flop synchroniser; request = sync_q1 & ~sync_q2.
REQ-016 On a request with busy low, data_in shall be snapshotted into an internal register in that cycle, and busy shall assert the next cycle.
REQ-017 Byte order: HEADER, [SEQ], word 0 MSB..LSB, word 1 MSB..LSB, ..., CHECKSUM, TRAILER.
REQ-018 Frame length shall be NUM_WORDS*WORD_BYTES+3 bytes, plus 1 when FRAME_SEQ_EN is defined.
REQ-019 CHECKSUM shall be the modulo-256 sum of all payload bytes (and SEQ if present), excluding HEADER and TRAILER.
REQ-020 The checksum shall accumulate as bytes are issued; no wide adder tree.
REQ-021 FSM states: IDLE, WAIT_RDY, PULSE, GAP.
REQ-022 IDLE -> WAIT_RDY on an accepted request.
REQ-023 WAIT_RDY -> PULSE when uart_tx_done=1; uart_tx_data and uart_tx_en=1 shall be registered in the same edge.
REQ-024 PULSE -> GAP unconditionally; uart_tx_en shall return to 0.
REQ-025 In GAP, uart_tx_done shall be ignored for exactly 1 cycle; then -> WAIT_RDY if bytes remain, else -> IDLE with frame_done=1.
REQ-026 uart_tx_data shall hold its value until the next byte is loaded.
REQ-027 A request while busy=1 shall not alter the frame in progress or the snapshot, and shall pulse frame_drop.
REQ-028 A request on the same cycle the FSM returns to IDLE counts as busy: it shall be dropped.
REQ-029 uart_tx_done held low indefinitely shall stall the FSM in WAIT_RDY with no timeout.

Reset
REQ-030 Asserting rst_n low shall clear all of the following immediately: uart_tx_en=0, uart_tx_data=8'h00, busy=0, frame_done=0, frame_drop=0, synchroniser=0, checksum=0, and FSM=IDLE.
REQ-031 Reset mid-frame shall abandon the frame; no residual pulse shall occur after release.

Configuration
REQ-032 With macro FRAME_SEQ_EN defined: an 8-bit sequence byte shall follow HEADER; it resets to 0 and increments (wrapping 255->0) after each completed frame only.
REQ-033 Without FRAME_SEQ_EN: no sequence byte and no sequence counter logic.

Verification
REQ-034 Defaults, SEQ off, data_in={32'h02FAF080,32'h00989680}, data_ready rise, uart_tx_done=1 -> bytes A5 00 98 96 80 02 FA F0 80 1A 5A, then frame_done pulse.
REQ-035 Same frame; hold uart_tx_done low 100 cycles after byte 3 -> the FSM stalls, no extra uart_tx_en pulses, and the frame completes intact.
REQ-036 Second data_ready rise mid-frame with changed data_in -> frame_drop pulses once, and the original bytes are sent unchanged.
REQ-037 rst_n low during byte 5, then new request -> the full 11-byte frame restarts from A5.
REQ-038 FRAME_SEQ_EN defined, 257 frames -> SEQ bytes 00..FF then 00; the checksum includes SEQ (first frame checksum 1A).
REQ-039 NUM_WORDS=1, WORD_BYTES=2, data_in=16'hFF02 -> bytes A5 FF 02 01 5A.
